mmult_result_streamer: RTL and testbench

Downstream stage of the `mmult` engine: captures each `mmult_results` word on `mmult_particular_datapoint_done`, buffers a full result vector of `m` words, then drains it as an AXI4-Stream master to the DMA/output FIFO. It also signals the controller when it can accept a new matrix-multiply run, and flags protocol errors.

---
 rtl/mmult_result_streamer.sv | 198 +++++++++++++++++++
 tb/tb_mmult_result_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmult_result_streamer.sv
// mmult_result_streamer
// Collects one result vector of m words from the mmult engine, then drains it
// as an AXI4-Stream master. collect_ready tells the controller when a new run
// may start; overflow_err and count_err are sticky protocol-error flags.
module mmult_result_streamer #(
    parameter int width      = 8,
    parameter int m          = 64,
    parameter int axis_width = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  res_valid,
    input  logic [width-1:0]      res_data,
    input  logic                  res_all_done,
    output logic                  collect_ready,
    output logic                  M_AXIS_TVALID,
    output logic [axis_width-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  stream_done,
    output logic                  overflow_err,
    output logic                  count_err
);

    // Counter width holds the value m itself; index width addresses 0..m-1.
    localparam int CNT_W = $clog2(m) + 1;
    localparam int IDX_W = (m > 1) ? $clog2(m) : 1;

    localparam logic [CNT_W-1:0] M_CNT    = CNT_W'(m);
    localparam logic [CNT_W-1:0] M_LAST   = CNT_W'(m - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;

    // Result word placed in the low bits of the stream beat, upper bits zero.
    function automatic logic [axis_width-1:0] zext(input logic [width-1:0] word);
        zext = axis_width'(word);
    endfunction

    logic [width-1:0]      data_buf [m];

    logic [1:0]            state_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      rd_ptr_r;
    logic                  tvalid_r;
    logic [axis_width-1:0] tdata_r;
    logic                  tlast_r;
    logic                  stream_done_r;
    logic                  overflow_err_r;
    logic                  count_err_r;
    logic                  collect_ready_r;
    logic                  all_done_prev_r;

    logic                  capture_s;
    logic                  handshake_s;
    logic                  all_done_rise_s;
    logic                  overflow_set_s;
    logic                  count_err_set_s;
    logic [CNT_W-1:0]      count_inc_s;
    logic [CNT_W-1:0]      rd_inc_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;

    logic [1:0]            state_next_s;
    logic [CNT_W-1:0]      count_next_s;
    logic [CNT_W-1:0]      rd_ptr_next_s;
    logic                  tvalid_next_s;
    logic [axis_width-1:0] tdata_next_s;
    logic                  tlast_next_s;
    logic                  stream_done_next_s;

    assign capture_s       = (state_r == ST_COLLECT) && res_valid;
    assign handshake_s     = (state_r == ST_STREAM) && tvalid_r && M_AXIS_TREADY;
    assign all_done_rise_s = res_all_done && !all_done_prev_r;
    assign overflow_set_s  = res_valid && (state_r != ST_COLLECT);
    assign count_inc_s     = count_r + CNT_W'(capture_s);
    assign rd_inc_s        = rd_ptr_r + CNT_ONE;
    assign wr_idx_s        = count_r[IDX_W-1:0];
    assign rd_idx_s        = rd_inc_s[IDX_W-1:0];

    // A done rise is fine only if the full vector is in, counting a capture on the same edge.
    always_comb begin
        count_err_set_s = 1'b0;
        if (!all_done_rise_s) begin
            count_err_set_s = 1'b0;
        end else if (state_r == ST_COLLECT) begin
            count_err_set_s = (count_inc_s != M_CNT);
        end else begin
            count_err_set_s = (count_r != M_CNT);
        end
    end

    // Next-state and next-output computation for the collect/load/stream sequence.
    always_comb begin
        state_next_s       = state_r;
        count_next_s       = count_r;
        rd_ptr_next_s      = rd_ptr_r;
        tvalid_next_s      = tvalid_r;
        tdata_next_s       = tdata_r;
        tlast_next_s       = tlast_r;
        stream_done_next_s = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (capture_s) begin
                    count_next_s = count_inc_s;
                    if (count_inc_s == M_CNT) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end else begin
                    count_next_s = count_r;
                    state_next_s = ST_COLLECT;
                end
            end
            ST_LOAD: begin
                tvalid_next_s = 1'b1;
                tdata_next_s  = zext(data_buf[0]);
                tlast_next_s  = (M_CNT == CNT_ONE);
                rd_ptr_next_s = CNT_ZERO;
                state_next_s  = ST_STREAM;
            end
            ST_STREAM: begin
                if (!handshake_s) begin
                    state_next_s = ST_STREAM;
                end else if (tlast_r) begin
                    tvalid_next_s      = 1'b0;
                    tlast_next_s       = 1'b0;
                    stream_done_next_s = 1'b1;
                    count_next_s       = CNT_ZERO;
                    state_next_s       = ST_COLLECT;
                end else begin
                    // Present the next word on the same edge so a held-high TREADY sees no bubble.
                    rd_ptr_next_s = rd_inc_s;
                    tdata_next_s  = zext(data_buf[rd_idx_s]);
                    tlast_next_s  = (rd_inc_s == M_LAST);
                    state_next_s  = ST_STREAM;
                end
            end
            default: begin
                state_next_s  = ST_COLLECT;
                count_next_s  = CNT_ZERO;
                rd_ptr_next_s = CNT_ZERO;
                tvalid_next_s = 1'b0;
                tdata_next_s  = {axis_width{1'b0}};
                tlast_next_s  = 1'b0;
            end
        endcase
    end

    // Result storage; contents are meaningless after reset so it carries none.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            data_buf[wr_idx_s] <= res_data;
        end
    end

    // State, counters, stream outputs and sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= ST_COLLECT;
            count_r         <= CNT_ZERO;
            rd_ptr_r        <= CNT_ZERO;
            tvalid_r        <= 1'b0;
            tdata_r         <= {axis_width{1'b0}};
            tlast_r         <= 1'b0;
            stream_done_r   <= 1'b0;
            overflow_err_r  <= 1'b0;
            count_err_r     <= 1'b0;
            collect_ready_r <= 1'b1;
            all_done_prev_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            count_r         <= count_next_s;
            rd_ptr_r        <= rd_ptr_next_s;
            tvalid_r        <= tvalid_next_s;
            tdata_r         <= tdata_next_s;
            tlast_r         <= tlast_next_s;
            stream_done_r   <= stream_done_next_s;
            overflow_err_r  <= overflow_err_r | overflow_set_s;
            count_err_r     <= count_err_r | count_err_set_s;
            collect_ready_r <= (state_next_s == ST_COLLECT);
            all_done_prev_r <= res_all_done;
        end
    end

    assign collect_ready = collect_ready_r;
    assign M_AXIS_TVALID = tvalid_r;
    assign M_AXIS_TDATA  = tdata_r;
    assign M_AXIS_TLAST  = tlast_r;
    assign stream_done   = stream_done_r;
    assign overflow_err  = overflow_err_r;
    assign count_err     = count_err_r;

endmodule

// File: tb/tb_mmult_result_streamer.sv
// Directed testbench for mmult_result_streamer with m=4, width=8, axis_width=32.
module tb_mmult_result_streamer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_all_done;
    logic        collect_ready;
    logic        M_AXIS_TVALID;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic        stream_done;
    logic        overflow_err;
    logic        count_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] beat_data [$];
    logic        beat_last [$];
    int          beat_cyc  [$];
    int          done_cyc;
    int          cyc = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    logic        tog_en = 1'b0;
    logic        tog_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          tog_i = 0;

    mmult_result_streamer #(.width(8), .m(4), .axis_width(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_all_done  (res_all_done),
        .collect_ready (collect_ready),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .stream_done   (stream_done),
        .overflow_err  (overflow_err),
        .count_err     (count_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records accepted beats, stream_done timing, and output stability while stalled.
    always @(negedge clk) begin
        cyc++;
        if (resetn && hold_pend) begin
            chk("hold_valid", M_AXIS_TVALID, 1'b1);
            chk("hold_data", M_AXIS_TDATA, hold_data);
            chk("hold_last", M_AXIS_TLAST, hold_last);
        end
        hold_pend = resetn && M_AXIS_TVALID && !M_AXIS_TREADY;
        hold_data = M_AXIS_TDATA;
        hold_last = M_AXIS_TLAST;
        if (resetn && M_AXIS_TVALID && M_AXIS_TREADY) begin
            beat_data.push_back(M_AXIS_TDATA);
            beat_last.push_back(M_AXIS_TLAST);
            beat_cyc.push_back(cyc);
        end
        if (stream_done) done_cyc = cyc;
    end

    // TREADY toggler used by the back-pressure test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                M_AXIS_TREADY = tog_pat[tog_i % 6];
                tog_i++;
            end
        end
    end

    task automatic clear_beats();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        done_cyc = -1;
    endtask

    // One res_valid pulse after gap idle cycles; returns #1 after the capturing edge.
    task automatic put(input logic [7:0] d, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_data  = d;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stream_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_beats(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk($sformatf("%s_nbeats", tag), beat_data.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), beat_data[i], {24'd0, e[i]});
                chk($sformatf("%s_last%0d", tag, i), beat_last[i], (i == 3) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        resetn        = 1'b0;
        res_valid     = 1'b0;
        res_data      = 8'h00;
        res_all_done  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        done_cyc      = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("rst_tdata", M_AXIS_TDATA, 32'h0);
        chk("rst_tlast", M_AXIS_TLAST, 1'b0);
        chk("rst_ready", collect_ready, 1'b1);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_done", stream_done, 1'b0);
        chk("rst_ovf", overflow_err, 1'b0);
        chk("rst_cerr", count_err, 1'b0);
        chk("rst_ready2", collect_ready, 1'b1);

        // Test 1: spaced pulses, TREADY high, done flag rising one cycle late.
        clear_beats();
        put(8'h10, 7);
        put(8'h20, 7);
        put(8'h30, 7);
        chk("t1_ready_mid", collect_ready, 1'b1);
        put(8'h40, 7);
        chk("t1_load_ready", collect_ready, 1'b0);
        chk("t1_load_tvalid", M_AXIS_TVALID, 1'b0);
        res_all_done = 1'b1;
        @(posedge clk);
        #1;
        chk("t1_first_tvalid", M_AXIS_TVALID, 1'b1);
        chk("t1_first_tdata", M_AXIS_TDATA, 32'h10);
        wait_done();
        res_all_done = 1'b0;
        check_beats("t1", 8'h10, 8'h20, 8'h30, 8'h40);
        if (beat_cyc.size() == 4) begin
            chk("t1_contig", beat_cyc[3] - beat_cyc[0], 32'd3);
            chk("t1_done_lat", done_cyc - beat_cyc[3], 32'd1);
        end
        chk("t1_ready_after", collect_ready, 1'b1);
        chk("t1_done_pulse", stream_done, 1'b0);
        chk("t1_cerr", count_err, 1'b0);

        // Test 2: same data with TREADY toggling.
        clear_beats();
        tog_i  = 0;
        tog_en = 1'b1;
        put(8'h10, 7);
        put(8'h20, 7);
        put(8'h30, 7);
        put(8'h40, 7);
        wait_done();
        tog_en = 1'b0;
        @(posedge clk);
        #1;
        M_AXIS_TREADY = 1'b1;
        check_beats("t2", 8'h10, 8'h20, 8'h30, 8'h40);

        // Test 3: four consecutive valid cycles.
        clear_beats();
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            res_data = 8'(i);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        wait_done();
        check_beats("t3", 8'h01, 8'h02, 8'h03, 8'h04);
        chk("t3_ovf", overflow_err, 1'b0);

        // Test 4: stray result during STREAM is dropped and flagged.
        clear_beats();
        M_AXIS_TREADY = 1'b0;
        put(8'h11, 1);
        put(8'h12, 1);
        put(8'h13, 1);
        put(8'h14, 1);
        put(8'hAA, 2);
        chk("t4_ovf", overflow_err, 1'b1);
        M_AXIS_TREADY = 1'b1;
        wait_done();
        check_beats("t4", 8'h11, 8'h12, 8'h13, 8'h14);

        // Test 5: early res_all_done, then completion and a clean run.
        clear_beats();
        put(8'h21, 2);
        put(8'h22, 2);
        put(8'h23, 2);
        chk("t5_cerr_pre", count_err, 1'b0);
        res_all_done = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_cerr", count_err, 1'b1);
        res_all_done = 1'b0;
        put(8'h24, 2);
        wait_done();
        check_beats("t5a", 8'h21, 8'h22, 8'h23, 8'h24);
        clear_beats();
        put(8'h31, 2);
        put(8'h32, 2);
        put(8'h33, 2);
        put(8'h34, 2);
        wait_done();
        check_beats("t5b", 8'h31, 8'h32, 8'h33, 8'h34);
        chk("t5_cerr_sticky", count_err, 1'b1);
        chk("t4_ovf_sticky", overflow_err, 1'b1);

        // Test 6: reset during the second beat.
        put(8'h41, 2);
        put(8'h42, 2);
        put(8'h43, 2);
        put(8'h44, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_beat2", M_AXIS_TDATA, 32'h42);
        resetn = 1'b0;
        #1;
        chk("t6_async_tvalid", M_AXIS_TVALID, 1'b0);
        chk("t6_async_tlast", M_AXIS_TLAST, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ready", collect_ready, 1'b1);
        chk("t6_ovf_clr", overflow_err, 1'b0);
        chk("t6_cerr_clr", count_err, 1'b0);
        clear_beats();
        put(8'h51, 2);
        put(8'h52, 2);
        put(8'h53, 2);
        put(8'h54, 2);
        wait_done();
        check_beats("t6", 8'h51, 8'h52, 8'h53, 8'h54);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
